// File: rtl/dma_mem_txn_tracer.sv
// Per-PE trace of DMA-to-memory-controller traffic: captures accepted write, read-request and
// read-data events on one selectable stream per lane and serialises them into a record FIFO.
module dma_mem_txn_tracer #(
   parameter int unsigned NUM_LANES   = 32,
   parameter int unsigned NUM_STREAMS = 2,
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TS_W        = 16
) (
   input  logic                                          clk,
   input  logic                                          reset_poweron_n,
   input  logic                                          cfg_enable,
   input  logic [$clog2(NUM_STREAMS)-1:0]                cfg_stream_sel,
   input  logic [2:0]                                    cfg_mode_mask,
   input  logic [NUM_LANES*NUM_STREAMS-1:0]              dma__memc__write_valid,
   input  logic [NUM_LANES*NUM_STREAMS*ADDR_W-1:0]       dma__memc__write_address,
   input  logic [NUM_LANES*NUM_STREAMS*DATA_W-1:0]       dma__memc__write_data,
   input  logic [NUM_LANES*NUM_STREAMS-1:0]              memc__dma__write_ready,
   input  logic [NUM_LANES*NUM_STREAMS-1:0]              dma__memc__read_valid,
   input  logic [NUM_LANES*NUM_STREAMS*ADDR_W-1:0]       dma__memc__read_address,
   input  logic [NUM_LANES*NUM_STREAMS-1:0]              dma__memc__read_pause,
   input  logic [NUM_LANES*NUM_STREAMS-1:0]              memc__dma__read_ready,
   input  logic [NUM_LANES*NUM_STREAMS-1:0]              memc__dma__read_data_valid,
   input  logic [NUM_LANES*NUM_STREAMS*DATA_W-1:0]       memc__dma__read_data,
   output logic                                          trc_valid,
   input  logic                                          trc_ready,
   output logic [2+$clog2(NUM_LANES)+TS_W+ADDR_W+DATA_W-1:0] trc_record,
   output logic [NUM_LANES-1:0]                          trc_overflow,
   output logic [15:0]                                   trc_drop_count,
   output logic [31:0]                                   trc_emit_count
);

   localparam int unsigned LW     = $clog2(NUM_LANES);
   localparam int unsigned SW     = $clog2(NUM_STREAMS);
   localparam int unsigned PW     = $clog2(FIFO_DEPTH);
   localparam int unsigned SLOT_W = TS_W + ADDR_W + DATA_W;
   localparam int unsigned REC_W  = 2 + LW + SLOT_W;

   logic [SW-1:0]     stream_q, stream_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [2:0]        occ_q [NUM_LANES];
   logic [2:0]        occ_d [NUM_LANES];
   logic [SLOT_W-1:0] slot_q [NUM_LANES][3];
   logic [SLOT_W-1:0] slot_d [NUM_LANES][3];
   logic [LW-1:0]     rr_q, rr_d;
   logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [NUM_LANES-1:0] ovf_q, ovf_d;
   logic [15:0]       drop_q, drop_d, drop_sum;
   logic [16:0]       drop_tot;
   logic [31:0]       emit_q, emit_d;

   logic [2:0]        ev [NUM_LANES];
   logic [SLOT_W-1:0] ev_slot [NUM_LANES][3];
   logic              found, can_push, do_grant, pop, taken, held;
   logic [LW-1:0]     gnt_lane, li;
   logic [1:0]        gnt_type;
   logic [REC_W-1:0]  gnt_rec;
   int unsigned       sum;

   // Per-lane event qualification on the active stream only.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [NUM_STREAMS-1:0] wv, wrdy, rv, rrdy, rp, dv;
      logic [ADDR_W-1:0]      wa [NUM_STREAMS];
      logic [ADDR_W-1:0]      ra [NUM_STREAMS];
      logic [DATA_W-1:0]      wd [NUM_STREAMS];
      logic [DATA_W-1:0]      rd [NUM_STREAMS];
      assign wv   = dma__memc__write_valid[l*NUM_STREAMS +: NUM_STREAMS];
      assign wrdy = memc__dma__write_ready[l*NUM_STREAMS +: NUM_STREAMS];
      assign rv   = dma__memc__read_valid[l*NUM_STREAMS +: NUM_STREAMS];
      assign rrdy = memc__dma__read_ready[l*NUM_STREAMS +: NUM_STREAMS];
      assign rp   = dma__memc__read_pause[l*NUM_STREAMS +: NUM_STREAMS];
      assign dv   = memc__dma__read_data_valid[l*NUM_STREAMS +: NUM_STREAMS];
      for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_strm
         assign wa[s] = dma__memc__write_address[(l*NUM_STREAMS+s)*ADDR_W +: ADDR_W];
         assign ra[s] = dma__memc__read_address[(l*NUM_STREAMS+s)*ADDR_W +: ADDR_W];
         assign wd[s] = dma__memc__write_data[(l*NUM_STREAMS+s)*DATA_W +: DATA_W];
         assign rd[s] = memc__dma__read_data[(l*NUM_STREAMS+s)*DATA_W +: DATA_W];
      end
      assign ev[l] = {cfg_enable & cfg_mode_mask[2] & dv[stream_q],
                      cfg_enable & cfg_mode_mask[1] & rv[stream_q] & rrdy[stream_q] & ~rp[stream_q],
                      cfg_enable & cfg_mode_mask[0] & wv[stream_q] & wrdy[stream_q]};
      assign ev_slot[l][0] = {ts_q, wa[stream_q], wd[stream_q]};
      assign ev_slot[l][1] = {ts_q, ra[stream_q], {DATA_W{1'b0}}};
      assign ev_slot[l][2] = {ts_q, {ADDR_W{1'b0}}, rd[stream_q]};
   end

   // Round-robin lane search from rr_q, fixed type priority inside a lane.
   always_comb begin
      found    = 1'b0;
      gnt_lane = '0;
      gnt_type = '0;
      li       = '0;
      sum      = 0;
      for (int i = 0; i < NUM_LANES; i++) begin
         sum = int'(rr_q) + i;
         if (sum >= NUM_LANES) sum = sum - NUM_LANES;
         li = LW'(sum);
         if (!found && (occ_q[li] != 3'b000)) begin
            found    = 1'b1;
            gnt_lane = li;
            gnt_type = occ_q[li][0] ? 2'd0 : (occ_q[li][1] ? 2'd1 : 2'd2);
         end
      end
      trc_valid = (cnt_q != '0);
      pop       = trc_valid && trc_ready;
      // A full FIFO still takes a push when the head leaves in the same cycle.
      can_push  = (cnt_q != (PW+1)'(FIFO_DEPTH)) || trc_ready;
      do_grant  = found && can_push;
      gnt_rec   = {gnt_type, gnt_lane, slot_q[gnt_lane][gnt_type]};
   end

   always_comb begin
      occ_d    = occ_q;
      slot_d   = slot_q;
      ovf_d    = ovf_q;
      drop_sum = '0;
      taken    = 1'b0;
      held     = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
         for (int t = 0; t < 3; t++) begin
            taken = do_grant && (gnt_lane == LW'(l)) && (gnt_type == 2'(t));
            held  = occ_q[l][t] && !taken;
            if (ev[l][t]) begin
               if (held) begin
                  ovf_d[l] = 1'b1;
                  drop_sum = drop_sum + 16'd1;
               end else begin
                  occ_d[l][t]  = 1'b1;
                  slot_d[l][t] = ev_slot[l][t];
               end
            end else if (taken) begin
               occ_d[l][t] = 1'b0;
            end
         end
      end
      drop_tot = {1'b0, drop_q} + {1'b0, drop_sum};
      drop_d   = drop_tot[16] ? 16'hFFFF : drop_tot[15:0];
      wr_ptr_d = wr_ptr_q + PW'(do_grant);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + (PW+1)'(do_grant) - (PW+1)'(pop);
      emit_d   = emit_q + 32'(pop);
      rr_d     = rr_q;
      if (do_grant) rr_d = (gnt_lane == LW'(NUM_LANES-1)) ? '0 : gnt_lane + LW'(1);
      ts_d     = ts_q + TS_W'(1);
      stream_d = cfg_enable ? stream_q : cfg_stream_sel;
   end

   always_ff @(posedge clk or negedge reset_poweron_n) begin
      if (!reset_poweron_n) begin
         stream_q <= '0;
         ts_q     <= '0;
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= '0;
         drop_q   <= '0;
         emit_q   <= '0;
         for (int l = 0; l < NUM_LANES; l++) occ_q[l] <= '0;
      end else begin
         stream_q <= stream_d;
         ts_q     <= ts_d;
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
         emit_q   <= emit_d;
         occ_q    <= occ_d;
      end
   end

   // Payload storage is qualified by occupancy/count, so it needs no reset.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
      if (do_grant) mem_q[wr_ptr_q] <= gnt_rec;
   end

   assign trc_record     = trc_valid ? mem_q[rd_ptr_q] : '0;
   assign trc_overflow   = ovf_q;
   assign trc_drop_count = drop_q;
   assign trc_emit_count = emit_q;

endmodule

// File: tb/tb_dma_mem_txn_tracer.sv
// Randomised and directed bench for dma_mem_txn_tracer against a queue-based event model.
module tb_dma_mem_txn_tracer;
   localparam int NL = 32, NS = 2, AW = 24, DW = 32, DEPTH = 8, TSW = 16;
   localparam int RW = 2 + 5 + TSW + AW + DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en, ready;
   logic [0:0] sel;
   logic [2:0] mask;
   logic [NL*NS-1:0] wv, wrdy, rv, rp, rrdy, dv;
   logic [NL*NS*AW-1:0] wa, ra;
   logic [NL*NS*DW-1:0] wd, rdat;
   logic trc_valid;
   logic [RW-1:0] trc_record;
   logic [NL-1:0] trc_overflow;
   logic [15:0] trc_drop_count;
   logic [31:0] trc_emit_count;

   dma_mem_txn_tracer #(
      .NUM_LANES(NL), .NUM_STREAMS(NS), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TS_W(TSW)
   ) dut (
      .clk(clk), .reset_poweron_n(rst_n), .cfg_enable(en), .cfg_stream_sel(sel),
      .cfg_mode_mask(mask), .dma__memc__write_valid(wv), .dma__memc__write_address(wa),
      .dma__memc__write_data(wd), .memc__dma__write_ready(wrdy), .dma__memc__read_valid(rv),
      .dma__memc__read_address(ra), .dma__memc__read_pause(rp), .memc__dma__read_ready(rrdy),
      .memc__dma__read_data_valid(dv), .memc__dma__read_data(rdat), .trc_valid(trc_valid),
      .trc_ready(ready), .trc_record(trc_record), .trc_overflow(trc_overflow),
      .trc_drop_count(trc_drop_count), .trc_emit_count(trc_emit_count)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // Reference model state.
   bit            m_occ  [NL][3];
   logic [RW-1:0] m_slot [NL][3];
   logic [RW-1:0] m_q[$];
   int            m_rr, m_ts, m_stream, m_drop;
   logic [NL-1:0] m_ovf;
   logic [31:0]   m_emit;
   logic [RW-1:0] obs[$];

   function automatic logic [RW-1:0] mk(int t, int l, int ts, logic [AW-1:0] a, logic [DW-1:0] d);
      return {2'(t), 5'(l), 16'(ts), a, d};
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int l = 0; l < NL; l++)
         for (int t = 0; t < 3; t++) begin
            m_occ[l][t] = 0;
            m_slot[l][t] = '0;
         end
      m_q.delete();
      m_rr = 0; m_ts = 0; m_stream = 0; m_drop = 0; m_ovf = '0; m_emit = '0;
   endtask

   task automatic clear_bus();
      wv = '0; wrdy = '0; rv = '0; rp = '0; rrdy = '0; dv = '0;
      wa = '0; ra = '0; wd = '0; rdat = '0;
   endtask

   task automatic model_step();
      bit can_push, pop, found;
      int gl, gt, idx;
      bit ev [3];
      logic [RW-1:0] rec [3];
      can_push = (m_q.size() < DEPTH) || ready;
      pop = (m_q.size() > 0) && ready;
      found = 0; gl = 0; gt = 0;
      for (int i = 0; i < NL; i++) begin
         int l;
         l = (m_rr + i) % NL;
         for (int t = 0; t < 3; t++)
            if (!found && m_occ[l][t]) begin
               found = 1; gl = l; gt = t;
            end
      end
      if (pop) begin
         void'(m_q.pop_front());
         m_emit++;
      end
      if (found && can_push) begin
         m_q.push_back(m_slot[gl][gt]);
         m_occ[gl][gt] = 0;
         m_rr = (gl + 1) % NL;
      end
      for (int l = 0; l < NL; l++) begin
         idx = l * NS + m_stream;
         ev[0] = en && mask[0] && wv[idx] && wrdy[idx];
         ev[1] = en && mask[1] && rv[idx] && rrdy[idx] && !rp[idx];
         ev[2] = en && mask[2] && dv[idx];
         rec[0] = mk(0, l, m_ts, wa[idx*AW +: AW], wd[idx*DW +: DW]);
         rec[1] = mk(1, l, m_ts, ra[idx*AW +: AW], '0);
         rec[2] = mk(2, l, m_ts, '0, rdat[idx*DW +: DW]);
         for (int t = 0; t < 3; t++)
            if (ev[t]) begin
               if (m_occ[l][t]) begin
                  m_ovf[l] = 1'b1;
                  if (m_drop < 65535) m_drop++;
               end else begin
                  m_occ[l][t] = 1;
                  m_slot[l][t] = rec[t];
               end
            end
      end
      if (!en) m_stream = int'(sel);
      m_ts = (m_ts + 1) % 65536;
   endtask

   task automatic compare_all();
      chk("valid", 128'(trc_valid), 128'(m_q.size() > 0));
      chk("record", 128'(trc_record), (m_q.size() > 0) ? 128'(m_q[0]) : 128'(0));
      chk("overflow", 128'(trc_overflow), 128'(m_ovf));
      chk("drop_count", 128'(trc_drop_count), 128'(m_drop));
      chk("emit_count", 128'(trc_emit_count), 128'(m_emit));
   endtask

   // Inputs are set at a negedge; one call advances one clock and checks after the edge.
   task automatic tick();
      if (trc_valid && ready) obs.push_back(trc_record);
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_bus();
      model_reset();
      obs.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      compare_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      en = 1'b0; sel = '0; mask = 3'b111; ready = 1'b0;
      clear_bus();
      model_reset();
      @(negedge clk);
      chk("rst_valid", 128'(trc_valid), 128'(0));
      chk("rst_record", 128'(trc_record), 128'(0));
      chk("rst_counts", 128'({trc_overflow, trc_drop_count, trc_emit_count}), 128'(0));

      // Single write on lane 5, stream 0.
      do_reset();
      en = 1'b1;
      wv[10] = 1'b1; wrdy[10] = 1'b1; wa[10*AW +: AW] = 24'h000123; wd[10*DW +: DW] = 32'hDEADBEEF;
      tick();
      clear_bus();
      tick();
      chk("single_valid", 128'(trc_valid), 128'(1));
      chk("single_rec", 128'(trc_record), 128'(mk(0, 5, 0, 24'h000123, 32'hDEADBEEF)));
      ready = 1'b1;
      tick();
      chk("single_emit", 128'(trc_emit_count), 128'(1));

      // Stream select loads only while disabled.
      do_reset();
      en = 1'b0; sel = 1'b1;
      tick();
      en = 1'b1; sel = 1'b0;
      rv[4] = 1'b1; rrdy[4] = 1'b1; ra[4*AW +: AW] = 24'h111111;
      rv[5] = 1'b1; rrdy[5] = 1'b1; ra[5*AW +: AW] = 24'h222222;
      tick();
      clear_bus();
      rv[4] = 1'b1; rrdy[4] = 1'b1; ra[4*AW +: AW] = 24'h333333;
      tick();
      clear_bus();
      for (int i = 0; i < 5; i++) tick();
      chk("sel_count", 128'(obs.size()), 128'(1));
      if (obs.size() > 0) chk("sel_rec", 128'(obs[0]), 128'(mk(1, 2, 1, 24'h222222, 32'h0)));

      // Round-robin over all lanes.
      do_reset();
      en = 1'b1; sel = 1'b0; ready = 1'b1;
      for (int l = 0; l < NL; l++) begin
         wv[2*l] = 1'b1; wrdy[2*l] = 1'b1;
         wa[2*l*AW +: AW] = 24'(l); wd[2*l*DW +: DW] = 32'(l) ^ 32'hFFFF0000;
      end
      tick();
      clear_bus();
      for (int i = 0; i < 40; i++) tick();
      chk("rr_count", 128'(obs.size()), 128'(32));
      for (int i = 0; i < obs.size(); i++)
         chk("rr_rec", 128'(obs[i]), 128'(mk(0, i, 0, 24'(i), 32'(i) ^ 32'hFFFF0000)));
      chk("rr_drops", 128'(trc_drop_count), 128'(0));

      // Backpressure and overflow on lane 7.
      do_reset();
      en = 1'b1; ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wv[14] = 1'b1; wrdy[14] = 1'b1; wa[14*AW +: AW] = 24'h700 + 24'(i); wd[14*DW +: DW] = 32'(i);
         tick();
      end
      clear_bus();
      tick(); tick();
      chk("bp_ovf", 128'(trc_overflow), 128'(32'h0000_0080));
      chk("bp_drop", 128'(trc_drop_count), 128'(1));
      ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("bp_count", 128'(obs.size()), 128'(9));
      for (int i = 0; i < obs.size(); i++)
         chk("bp_rec", 128'(obs[i]), 128'(mk(0, 7, i, 24'h700 + 24'(i), 32'(i))));

      // Same-lane priority on lane 3.
      do_reset();
      en = 1'b1; ready = 1'b1;
      wv[6] = 1'b1; wrdy[6] = 1'b1; wa[6*AW +: AW] = 24'hAAAAAA; wd[6*DW +: DW] = 32'h11111111;
      rv[6] = 1'b1; rrdy[6] = 1'b1; ra[6*AW +: AW] = 24'hBBBBBB;
      dv[6] = 1'b1; rdat[6*DW +: DW] = 32'h22222222;
      tick();
      clear_bus();
      for (int i = 0; i < 6; i++) tick();
      chk("prio_count", 128'(obs.size()), 128'(3));
      if (obs.size() == 3) begin
         chk("prio_wr", 128'(obs[0]), 128'(mk(0, 3, 0, 24'hAAAAAA, 32'h11111111)));
         chk("prio_rq", 128'(obs[1]), 128'(mk(1, 3, 0, 24'hBBBBBB, 32'h0)));
         chk("prio_rd", 128'(obs[2]), 128'(mk(2, 3, 0, 24'h0, 32'h22222222)));
      end

      // Asynchronous reset with records queued.
      do_reset();
      en = 1'b1; ready = 1'b0;
      for (int l = 0; l < 5; l++) begin
         wv[2*l] = 1'b1; wrdy[2*l] = 1'b1; wa[2*l*AW +: AW] = 24'h10 + 24'(l);
      end
      tick();
      clear_bus();
      for (int i = 0; i < 6; i++) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("mid_emit", 128'(trc_emit_count), 128'(1));
      chk("mid_valid", 128'(trc_valid), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 128'(trc_valid), 128'(0));
      chk("async_record", 128'(trc_record), 128'(0));
      chk("async_counts", 128'({trc_drop_count, trc_emit_count}), 128'(0));
      model_reset();
      obs.delete();
      @(negedge clk);
      rst_n = 1'b1;
      wv[18] = 1'b1; wrdy[18] = 1'b1; wa[18*AW +: AW] = 24'h000999; wd[18*DW +: DW] = 32'hCAFEF00D;
      tick();
      clear_bus();
      tick();
      chk("post_rst_rec", 128'(trc_record), 128'(mk(0, 9, 0, 24'h000999, 32'hCAFEF00D)));

      // Randomised traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         en = (c % 250) >= 3;
         if (!en) sel = 1'($urandom_range(0, 1));
         if (c % 500 == 0) mask = (c == 0) ? 3'b111 : 3'($urandom_range(0, 7));
         ready = ((c / 100) % 5 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NL * NS; i++) begin
            wv[i] = ($urandom_range(0, 15) == 0); wrdy[i] = ($urandom_range(0, 3) != 0);
            rv[i] = ($urandom_range(0, 15) == 0); rrdy[i] = ($urandom_range(0, 3) != 0);
            rp[i] = ($urandom_range(0, 3) == 0);  dv[i] = ($urandom_range(0, 15) == 0);
            wa[i*AW +: AW] = 24'($urandom); ra[i*AW +: AW] = 24'($urandom);
            wd[i*DW +: DW] = $urandom; rdat[i*DW +: DW] = $urandom;
         end
         tick();
      end
      clear_bus();
      ready = 1'b1;
      for (int i = 0; i < 150; i++) tick();
      chk("drain_empty", 128'(trc_valid), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
